prog_sequencer: RTL
===================

Name: prog_sequencer

Overview:
- Synthesizable multi-program run controller for the single-cycle core `top`.
- For each of NUM_PROGS configured programs it:
  - holds the core in reset, sets the start PC and releases it;
  - waits for `done`, with a timeout;
  - reads 1..RES_BYTES result bytes, big-endian, from data memory through a check port and compares them with the expected value.
- Reports per-program pass/fail/timeout masks. It replaces hand-sequenced reset pulsing between program runs.

Parameters:
- NUM_PROGS, 3, number of program slots.
- ADDR_W, 8, data-memory address width.
- PC_W, 10, core start-PC width.
- RES_BYTES, 2, maximum result length in bytes.
- RST_CYCLES, 2, cycles `core_reset` is held per program (≥1).
- TMO_W, 16, timeout counter width. Timeout fires after 2^TMO_W−1 RUN cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a sequence when IDLE, ignored otherwise
- cfg_we  in  1  config write strobe; accepted only when IDLE
- cfg_idx  in  $clog2(NUM_PROGS)  slot being written; idx ≥ NUM_PROGS is ignored
- cfg_pc  in  PC_W  start PC for the slot
- cfg_addr  in  ADDR_W  address of the first (MS) result byte
- cfg_len  in  $clog2(RES_BYTES)+1  result bytes, 1..RES_BYTES; 0 = slot disabled (skipped)
- cfg_exp  in  8*RES_BYTES  expected value, right-justified
- core_reset  out  1  drives the core's reset
- core_start_pc  out  PC_W  PC loaded by the core while in reset
- core_done  in  1  core's `done` level
- chk_addr  out  ADDR_W  data-memory read address
- chk_rdata  in  8  read data, valid 1 cycle after chk_addr
- busy  out  1  sequence in progress
- seq_done  out  1  one-cycle pulse at sequence end
- cur_prog  out  $clog2(NUM_PROGS)  slot being run
- pass_mask, fail_mask, tmo_mask  out  NUM_PROGS  per-slot results
- stat_idx  in  $clog2(NUM_PROGS)  cycle-count read select
- stat_cycles  out  TMO_W  RUN cycles of the selected slot

Behaviour:
- Reset values:
  - core_reset=1; core_start_pc=0; chk_addr=0.
  - busy=0, seq_done=0, cur_prog=0.
  - All masks 0; all config slots len=0.
  - The core stays in reset whenever the FSM is IDLE.
- States: IDLE → SEL → CRST → RUN → RD → CMP → SEL … → FIN → IDLE.
- IDLE:
  - On start: clear all masks, cur_prog=0, busy=1 on the next cycle; go to SEL.
  - cfg_we writes the slot the same cycle.
- SEL:
  - If cur_prog's len=0: its mask bits stay 0; advance cur_prog (1 cycle).
  - Else: core_start_pc = slot pc; go to CRST.
  - Past the last slot: go to FIN.
- CRST: core_reset=1 for exactly RST_CYCLES cycles, then RUN with core_reset=0 and timer cleared.
- RUN:
  - core_done is ignored in the first RUN cycle, which masks any stale done from the previous program.
  - From cycle 2, core_done=1 → RD.
  - If the timer reaches all-ones first: set tmo_mask[cur], core_reset=1, go to SEL for the next slot.
  - Timer increments every RUN cycle and saturates.
- RD/CMP:
  - chk_addr = addr+k for k=0..len−1, one address per cycle; the address wraps modulo 2^ADDR_W.
  - Each returned byte is shifted into an accumulator one cycle later.
  - After the last byte, compare accumulator[8*len−1:0] with cfg_exp[8*len−1:0]; set pass_mask or fail_mask for the slot; core_reset=1; go to SEL.
  - The core is held in reset again from CMP onward.
- FIN: seq_done=1 for one cycle, busy=0, go to IDLE. Masks hold until the next start.
- start while busy: ignored. cfg_we while busy: ignored, and config stays frozen for the run.
- reset mid-sequence: immediate return to IDLE with reset values. Config is also cleared.
- Exactly one of pass/fail/tmo is set per enabled slot.

Optional Feature:
- SEQ_CYCLE_COUNT_EN defined:
  - Per-slot TMO_W cycle registers capture the RUN timer value at done/timeout.
  - stat_cycles = count[stat_idx], combinational read.
  - Registers are cleared on start and on reset.
- Undefined: stat_cycles is tied to 0 and no count registers exist.

Test Plan:
- Three-program sequence:
  - Setup: slot0 len=2 exp=16'd150 @addr 4; slot1 len=1 exp=8'd6 @7; slot2 len=1 exp=8'd3 @127.
  - Core model: memory preloaded with matching data; done after 40, 900 and 3000 cycles.
  - Required: pass_mask=3'b111, fail/tmo=0, one seq_done pulse.
  - With SEQ_CYCLE_COUNT_EN: stat_cycles = 40/900/3000.
- Mismatch: slot1 memory returns 5 against exp 6 → fail_mask=3'b010, pass_mask=3'b101.
- Timeout: TMO_W=6, slot0 core_done never asserts → tmo_mask[0]=1 after 63 RUN cycles; slots 1 and 2 still run and pass.
- Disabled slot and wrap: slot1 len=0 → slot1 is never reset or run, all its mask bits 0. Slot0 addr=8'hFF len=2 → reads 0xFF then 0x00.
- Stale done: core_done held at 1 across programs → each slot still gets RST_CYCLES of core_reset, and done is not taken in the first RUN cycle.
- Reset at RUN cycle 10: next cycle busy=0, core_reset=1, masks 0; a new start with fresh config runs cleanly.

Source files
------------

// File: rtl/prog_sequencer.sv
// Multi-program run controller: for each configured slot it resets and launches the core, waits
// for done (with timeout) and checks a big-endian result in data memory. SEQ_CYCLE_COUNT_EN adds
// per-slot RUN cycle counters.
module prog_sequencer #(
  parameter int unsigned NUM_PROGS  = 3,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned PC_W       = 10,
  parameter int unsigned RES_BYTES  = 2,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TMO_W      = 16,
  localparam int unsigned IDX_W = $clog2(NUM_PROGS),
  localparam int unsigned LEN_W = $clog2(RES_BYTES) + 1,
  localparam int unsigned EXP_W = 8 * RES_BYTES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [PC_W-1:0]      cfg_pc,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [EXP_W-1:0]     cfg_exp,
  output logic                 core_reset,
  output logic [PC_W-1:0]      core_start_pc,
  input  logic                 core_done,
  output logic [ADDR_W-1:0]    chk_addr,
  input  logic [7:0]           chk_rdata,
  output logic                 busy,
  output logic                 seq_done,
  output logic [IDX_W-1:0]     cur_prog,
  output logic [NUM_PROGS-1:0] pass_mask,
  output logic [NUM_PROGS-1:0] fail_mask,
  output logic [NUM_PROGS-1:0] tmo_mask,
  input  logic [IDX_W-1:0]     stat_idx,
  output logic [TMO_W-1:0]     stat_cycles
);

  localparam int unsigned      SLOTS   = 2 ** IDX_W;
  localparam int unsigned      RC_W    = $clog2(RST_CYCLES) + 1;
  localparam logic [IDX_W:0]   ProgEnd = (IDX_W + 1)'(NUM_PROGS);
  localparam logic [TMO_W-1:0] TmoLast = {TMO_W{1'b1}} - 1'b1;

  typedef enum logic [2:0] {StIdle, StSel, StCrst, StRun, StRd, StCmp, StFin} state_e;

  state_e              state_q, state_d;
  logic [IDX_W:0]      prog_q, prog_d;
  logic [RC_W-1:0]     rcnt_q, rcnt_d;
  logic [TMO_W-1:0]    timer_q, timer_d;
  logic [LEN_W-1:0]    byte_q, byte_d;
  logic [EXP_W-1:0]    acc_q, acc_d;
  logic [ADDR_W-1:0]   chk_addr_q, chk_addr_d;
  logic [PC_W-1:0]     start_pc_q, start_pc_d;
  logic [NUM_PROGS-1:0] pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d;

  // Slot table is padded to a power of two; padding slots stay disabled.
  logic [PC_W-1:0]     pc_q   [SLOTS];
  logic [PC_W-1:0]     pc_d   [SLOTS];
  logic [ADDR_W-1:0]   addr_q [SLOTS];
  logic [ADDR_W-1:0]   addr_d [SLOTS];
  logic [LEN_W-1:0]    len_q  [SLOTS];
  logic [LEN_W-1:0]    len_d  [SLOTS];
  logic [EXP_W-1:0]    exp_q  [SLOTS];
  logic [EXP_W-1:0]    exp_d  [SLOTS];

  logic [IDX_W-1:0]    cur_idx;
  logic [LEN_W-1:0]    cur_len;
  logic [EXP_W-1:0]    len_mask;
  logic [EXP_W-1:0]    acc_shift;
  logic                cfg_ok, seq_start, run_done, run_tmo, match;

  assign cur_idx   = prog_q[IDX_W-1:0];
  assign cur_len   = len_q[cur_idx];
  assign cfg_ok    = {1'b0, cfg_idx} < ProgEnd;
  assign seq_start = (state_q == StIdle) && start;
  // First RUN cycle (timer still 0) ignores done so a stale level from the last program is masked.
  assign run_done  = (state_q == StRun) && core_done && (timer_q != '0);
  assign run_tmo   = (state_q == StRun) && !run_done && (timer_q == TmoLast);
  assign acc_shift = (acc_q << 8) | EXP_W'(chk_rdata);
  assign match     = ((acc_shift ^ exp_q[cur_idx]) & len_mask) == '0;

  always_comb begin
    len_mask = '0;
    for (int b = 0; b < int'(RES_BYTES); b++) begin
      if (b < int'(cur_len)) len_mask[8*b +: 8] = 8'hff;
    end
  end

  always_comb begin
    state_d    = state_q;
    prog_d     = prog_q;
    rcnt_d     = rcnt_q;
    timer_d    = timer_q;
    byte_d     = byte_q;
    acc_d      = acc_q;
    chk_addr_d = chk_addr_q;
    start_pc_d = start_pc_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    tmo_d      = tmo_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    len_d      = len_q;
    exp_d      = exp_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_we && cfg_ok) begin
          pc_d[cfg_idx]   = cfg_pc;
          addr_d[cfg_idx] = cfg_addr;
          len_d[cfg_idx]  = (cfg_len > LEN_W'(RES_BYTES)) ? LEN_W'(RES_BYTES) : cfg_len;
          exp_d[cfg_idx]  = cfg_exp;
        end
        if (start) begin
          pass_d  = '0;
          fail_d  = '0;
          tmo_d   = '0;
          prog_d  = '0;
          state_d = StSel;
        end
      end
      StSel: begin
        if (prog_q == ProgEnd) begin
          state_d = StFin;
        end else if (cur_len == '0) begin
          prog_d = prog_q + 1'b1;
        end else begin
          start_pc_d = pc_q[cur_idx];
          rcnt_d     = '0;
          state_d    = StCrst;
        end
      end
      StCrst: begin
        if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
          timer_d = '0;
          state_d = StRun;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      StRun: begin
        if (run_done) begin
          chk_addr_d = addr_q[cur_idx];
          byte_d     = '0;
          acc_d      = '0;
          state_d    = StRd;
        end else if (run_tmo) begin
          timer_d          = '1;
          tmo_d[cur_idx]   = 1'b1;
          prog_d           = prog_q + 1'b1;
          state_d          = StSel;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRd: begin
        // Read data lags the address by one cycle, so byte k lands while address k+1 is out.
        if (byte_q != '0) acc_d = acc_shift;
        if (byte_q == cur_len - 1'b1) begin
          state_d = StCmp;
        end else begin
          byte_d     = byte_q + 1'b1;
          chk_addr_d = chk_addr_q + 1'b1;
        end
      end
      StCmp: begin
        acc_d = acc_shift;
        if (match) pass_d[cur_idx] = 1'b1;
        else       fail_d[cur_idx] = 1'b1;
        prog_d  = prog_q + 1'b1;
        state_d = StSel;
      end
      StFin: begin
        prog_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      prog_q     <= '0;
      rcnt_q     <= '0;
      timer_q    <= '0;
      byte_q     <= '0;
      acc_q      <= '0;
      chk_addr_q <= '0;
      start_pc_q <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      tmo_q      <= '0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        pc_q[i]   <= '0;
        addr_q[i] <= '0;
        len_q[i]  <= '0;
        exp_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      prog_q     <= prog_d;
      rcnt_q     <= rcnt_d;
      timer_q    <= timer_d;
      byte_q     <= byte_d;
      acc_q      <= acc_d;
      chk_addr_q <= chk_addr_d;
      start_pc_q <= start_pc_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      tmo_q      <= tmo_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      exp_q      <= exp_d;
    end
  end

`ifdef SEQ_CYCLE_COUNT_EN
  logic [TMO_W-1:0] cnt_q [SLOTS];
  logic [TMO_W-1:0] cnt_d [SLOTS];

  always_comb begin
    cnt_d = cnt_q;
    if (seq_start) begin
      for (int i = 0; i < int'(SLOTS); i++) cnt_d[i] = '0;
    end else if (run_done) begin
      cnt_d[cur_idx] = timer_q;
    end else if (run_tmo) begin
      cnt_d[cur_idx] = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(SLOTS); i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stat_cycles = cnt_q[stat_idx];
`else
  logic unused_stat;
  assign unused_stat = ^stat_idx ^ seq_start;
  assign stat_cycles = '0;
`endif

  // Core runs only in RUN and RD; every other state holds it in reset.
  assign core_reset    = !((state_q == StRun) || (state_q == StRd));
  assign core_start_pc = start_pc_q;
  assign chk_addr      = chk_addr_q;
  assign busy          = (state_q != StIdle) && (state_q != StFin);
  assign seq_done      = (state_q == StFin);
  assign cur_prog      = cur_idx;
  assign pass_mask     = pass_q;
  assign fail_mask     = fail_q;
  assign tmo_mask      = tmo_q;

endmodule
